// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: RV32I size decode,
// byte-lane stores, extended loads, and a fixed number of wait states.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNTW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [2:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic              go_resp;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [2:0]        cur_size;
  logic [31:0]       cur_wdata;
  logic [IDXW-1:0]   idx;
  logic [31:0]       word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [3:0]        be;
  logic [31:0]       wdata_al;
  logic              illegal, misalign, oor;

  assign accept  = req_valid && req_ready;
  assign go_resp = (state_q != RESP) && (state_d == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNTW'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !rst;
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
    end
  end

  // With no wait states the access completes on the accept edge, so decode
  // straight from the request port instead of the not-yet-latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_size  = req_size;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    illegal  = (cur_size == 3'b011) || (cur_size == 3'b110) || (cur_size == 3'b111) ||
               (cur_we && cur_size[2]);
    misalign = ((cur_size[1:0] == 2'b01) && cur_addr[0]) ||
               ((cur_size[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    oor      = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    err_d    = illegal || misalign || oor;

    idx      = cur_addr[IDXW+1:2];
    word     = mem_q[idx];
    case (cur_addr[1:0])
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = cur_addr[1] ? word[31:16] : word[15:0];

    case (cur_size)
      3'b000:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
      3'b010:  rdata_d = word;
      3'b100:  rdata_d = {24'b0, byte_sel};
      3'b101:  rdata_d = {16'b0, half_sel};
      default: rdata_d = 32'b0;
    endcase
    if (err_d || cur_we) rdata_d = 32'b0;

    case (cur_size[1:0])
      2'b00:   be = 4'b0001 << cur_addr[1:0];
      2'b01:   be = cur_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    case (cur_size[1:0])
      2'b00:   wdata_al = {4{cur_wdata[7:0]}};
      2'b01:   wdata_al = {2{cur_wdata[15:0]}};
      default: wdata_al = cur_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (go_resp) begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; a store lands only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (!rst && go_resp && cur_we && !err_d) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: handshake timing, size decode, errors,
// backpressure and reset during a pending store.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access with resp_ready held high; reports data, error and
  // accept-to-valid latency in cycles.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int lat);
    int n;
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_size   = size;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("acceptReady", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic doAccess(input string tag, input logic we, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [31:0] expData, input logic expErr);
    logic [31:0] rd;
    logic        er;
    int          lat;
    applyStimulus(we, addr, size, wdata, rd, er, lat);
    checkOutput({tag, ".lat"},  32'(lat), 32'd2);
    checkOutput({tag, ".data"}, rd, expData);
    checkOutput({tag, ".err"},  {31'b0, er}, {31'b0, expErr});
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_size   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReqReady",  {31'b0, req_ready},  32'd0);
    checkOutput("rstRespValid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rstRdata",     resp_rdata,          32'd0);
    checkOutput("rstErr",       {31'b0, resp_err},   32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("postRstReady", {31'b0, req_ready}, 32'd1);

    // Basic word store/load and sub-word extraction
    doAccess("swDeadbeef", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0);
    doAccess("lw10",       1'b0, 32'h10, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0);
    doAccess("lb13",       1'b0, 32'h13, 3'b000, 32'h0,        32'hFFFFFFDE, 1'b0);
    doAccess("lbu13",      1'b0, 32'h13, 3'b100, 32'h0,        32'h000000DE, 1'b0);
    doAccess("lh10",       1'b0, 32'h10, 3'b001, 32'h0,        32'hFFFFBEEF, 1'b0);
    doAccess("lhu12",      1'b0, 32'h12, 3'b101, 32'h0,        32'h0000DEAD, 1'b0);
    doAccess("sb11",       1'b1, 32'h11, 3'b000, 32'hAAAAAA55, 32'h0,        1'b0);
    doAccess("lw10AfterSb",1'b0, 32'h10, 3'b010, 32'h0,        32'hDEAD55EF, 1'b0);

    // Upper-half store and the last valid word
    doAccess("sw14",       1'b1, 32'h14, 3'b010, 32'h11223344, 32'h0,        1'b0);
    doAccess("sh16",       1'b1, 32'h16, 3'b001, 32'hFFFFA5C3, 32'h0,        1'b0);
    doAccess("lw14",       1'b0, 32'h14, 3'b010, 32'h0,        32'hA5C33344, 1'b0);
    doAccess("lb15",       1'b0, 32'h15, 3'b000, 32'h0,        32'h00000033, 1'b0);
    doAccess("swLast",     1'b1, 32'hFFC, 3'b010, 32'h0BADF00D, 32'h0,       1'b0);
    doAccess("lwLast",     1'b0, 32'hFFC, 3'b010, 32'h0,       32'h0BADF00D, 1'b0);

    // Rejected accesses must not touch storage
    doAccess("lwMisalign", 1'b0, 32'h12,       3'b010, 32'h0,        32'h0, 1'b1);
    doAccess("shMisalign", 1'b1, 32'h11,       3'b001, 32'h0000FFFF, 32'h0, 1'b1);
    doAccess("lwOor",      1'b0, 32'h1000,     3'b010, 32'h0,        32'h0, 1'b1);
    doAccess("lwHighAddr", 1'b0, 32'h80000010, 3'b010, 32'h0,        32'h0, 1'b1);
    doAccess("swHighAddr", 1'b1, 32'h80000010, 3'b010, 32'h01020304, 32'h0, 1'b1);
    doAccess("size011",    1'b0, 32'h10,       3'b011, 32'h0,        32'h0, 1'b1);
    doAccess("storeSz100", 1'b1, 32'h10,       3'b100, 32'h00000077, 32'h0, 1'b1);
    doAccess("lw10AfterErr", 1'b0, 32'h10,     3'b010, 32'h0, 32'hDEAD55EF, 1'b0);

    // Backpressure: response must hold while resp_ready is low
    begin
      int n;
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 32'h10;
      req_size   = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      for (int i = 0; i < 5; i++) begin
        checkOutput("bpValid", {31'b0, resp_valid}, 32'd1);
        checkOutput("bpData",  resp_rdata,          32'hDEAD55EF);
        checkOutput("bpReady", {31'b0, req_ready},  32'd0);
        @(negedge clk);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bpRelValid", {31'b0, resp_valid}, 32'd0);
      checkOutput("bpRelReady", {31'b0, req_ready},  32'd1);
    end

    // Reset while a store waits: the store must be dropped
    doAccess("preload20", 1'b1, 32'h20, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_size  = 3'b010;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRstValid", {31'b0, resp_valid}, 32'd0);
    checkOutput("midRstReady", {31'b0, req_ready},  32'd0);
    rst = 1'b0;
    doAccess("lw20AfterRst", 1'b0, 32'h20, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
